// File: rtl/counter_sequencer.sv
// Configurable terminal-count sequencer: a config handshake loads the limit
// and the reload mode, start launches a run, halt pauses it and abort
// cancels it. One-shot runs return to ARMED with the config kept, so a
// further start reruns with the same limit. Periodic runs reload forever.
module counter_sequencer #(
  parameter int G_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [G_WIDTH-1:0] cfg_limit,
  input  logic               cfg_periodic,
  input  logic               start,
  input  logic               halt,
  input  logic               abort,
  output logic [G_WIDTH-1:0] count,
  output logic               busy,
  output logic               tick,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t               state, state_nxt;
  logic [G_WIDTH-1:0]   count_nxt;
  logic [G_WIDTH-1:0]   lim_q, lim_nxt;
  logic                 per_q, per_nxt;
  logic                 tick_nxt, done_nxt;

  // Configuration is accepted only while the counter is not running.
  assign cfg_ready = (state == S_IDLE) || (state == S_ARMED);
  assign busy      = (state == S_RUN)  || (state == S_PAUSE);

  // State and datapath registers; reset discards both the run and the config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      lim_q <= '0;
      per_q <= 1'b0;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lim_q <= lim_nxt;
      per_q <= per_nxt;
      tick  <= tick_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state, counter and pulse decisions.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lim_nxt   = lim_q;
    per_nxt   = per_q;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          lim_nxt   = cfg_limit;
          per_nxt   = cfg_periodic;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        // A config arriving with start is latched here and used by the
        // run, since the terminal compare only looks at lim_q from RUN.
        if (cfg_valid) begin
          lim_nxt = cfg_limit;
          per_nxt = cfg_periodic;
        end
        if (start) begin
          state_nxt = S_RUN;
          count_nxt = '0;
        end
      end
      S_RUN, S_PAUSE: begin
        // PAUSE with halt released performs the RUN action on that same
        // edge, so the run loses exactly one cycle per halted edge.
        if (abort) begin
          count_nxt = '0;
          state_nxt = S_ARMED;
        end else if (halt) begin
          state_nxt = S_PAUSE;
        end else if (count == lim_q) begin
          count_nxt = '0;
          tick_nxt  = 1'b1;
          if (per_q) begin
            state_nxt = S_RUN;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_ARMED;
          end
        end else begin
          count_nxt = count + G_WIDTH'(1);
          state_nxt = S_RUN;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer (G_WIDTH=4): directed scenarios
// followed by randomized traffic, all compared against a progress-based
// reference model.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_limit = '0;
  logic       cfg_periodic = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       tick;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Reference model: a run is described by the number of edges it has
  // actually advanced since its start edge; count is that progress modulo
  // the period (limit+1), and a wrap happens whenever the progress reaches
  // a multiple of the period.
  bit m_cfgd, m_act, m_per;
  int m_lim, m_prog;
  int e_count;
  bit e_tick, e_done;

  counter_sequencer #(.G_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_limit(cfg_limit), .cfg_periodic(cfg_periodic), .start(start),
    .halt(halt), .abort(abort), .count(count), .busy(busy), .tick(tick),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(e_count));
    chk({tag, ".tick"},      32'(tick),      32'(e_tick));
    chk({tag, ".done"},      32'(done),      32'(e_done));
    chk({tag, ".busy"},      32'(busy),      32'(m_act));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_act));
  endtask

  task automatic model_reset();
    m_cfgd = 0; m_act = 0; m_per = 0; m_lim = 0; m_prog = 0;
    e_count = 0; e_tick = 0; e_done = 0;
  endtask

  task automatic model_edge(input bit cv, input int lm, input bit pr,
                            input bit st, input bit h, input bit ab);
    bit go;
    e_tick = 0;
    e_done = 0;
    if (!m_act) begin
      go = m_cfgd && st;
      if (cv) begin
        m_lim = lm; m_per = pr; m_cfgd = 1;
      end
      if (go) begin
        m_act = 1; m_prog = 0;
      end
      e_count = 0;
    end else if (ab) begin
      m_act = 0;
      e_count = 0;
    end else if (!h) begin
      m_prog++;
      e_count = m_prog % (m_lim + 1);
      if (e_count == 0) begin
        e_tick = 1;
        if (!m_per) begin
          e_done = 1;
          m_act = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, check 1 time unit past the edge.
  task automatic step(input string tag, input bit cv, input int lm, input bit pr,
                      input bit st, input bit h, input bit ab);
    cfg_valid = cv; cfg_limit = 4'(lm); cfg_periodic = pr;
    start = st; halt = h; abort = ab;
    @(posedge clk);
    model_edge(cv, lm, pr, st, h, ab);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
    #1;
    check_all({tag, ".release"});
  endtask

  initial begin
    model_reset();
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all("por_release");

    // Start in IDLE is ignored.
    step("idle_start", 0, 0, 0, 1, 0, 0);

    // One-shot, limit 3: 0,1,2,3,0 with tick+done 4 edges after start.
    step("os_cfg", 1, 3, 0, 0, 0, 0);
    step("os_start", 0, 0, 0, 1, 0, 0);
    idle("os_run", 6);

    // Periodic, limit 15, three periods; a config during the run is ignored.
    step("p15_cfg", 1, 15, 1, 0, 0, 0);
    step("p15_start", 0, 0, 0, 1, 0, 0);
    step("p15_cfg_busy", 1, 1, 0, 1, 0, 0);
    idle("p15_run", 47);
    step("p15_abort", 0, 0, 0, 0, 0, 1);

    // Halt for 3 edges at count 2, limit 9 (one-shot).
    step("h9_cfg", 1, 9, 0, 0, 0, 0);
    step("h9_start", 0, 0, 0, 1, 0, 0);
    idle("h9_pre", 2);
    for (int i = 0; i < 3; i++) step("h9_halt", 0, 0, 0, 0, 1, 0);
    idle("h9_post", 10);

    // Halt at count == limit 5: terminal action deferred until resume.
    step("h5_cfg", 1, 5, 1, 0, 0, 0);
    step("h5_start", 0, 0, 0, 1, 0, 0);
    idle("h5_pre", 5);
    for (int i = 0; i < 2; i++) step("h5_halt", 0, 0, 0, 0, 1, 0);
    idle("h5_post", 2);
    step("h5_abort", 0, 0, 0, 0, 1, 1);

    // Abort at count 7, limit 12; abort when ARMED does nothing; rerun.
    step("ab_cfg", 1, 12, 0, 0, 0, 0);
    step("ab_start", 0, 0, 0, 1, 0, 0);
    idle("ab_pre", 7);
    step("ab_abort", 0, 0, 0, 0, 0, 1);
    step("ab_armed_abort", 0, 0, 0, 0, 0, 1);
    step("ab_restart", 0, 0, 0, 1, 0, 0);
    idle("ab_rerun", 14);

    // Config and start on the same ARMED edge, limit 2 periodic.
    step("cs_both", 1, 2, 1, 1, 0, 0);
    idle("cs_run", 10);
    do_reset("cs_reset");
    step("cs_post_start", 0, 0, 0, 1, 0, 0);

    // Max limit one-shot wraps from all-ones with tick and done.
    step("max_cfg", 1, 15, 0, 0, 0, 0);
    step("max_start", 0, 0, 0, 1, 0, 0);
    idle("max_run", 17);

    // Limit 0 periodic: tick every cycle.
    step("z_cfg", 1, 0, 1, 1, 0, 0);
    idle("z_run", 4);
    step("z_abort", 0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 150 == 0) begin
        do_reset("rnd_reset");
      end else begin
        step("rnd",
             ($urandom % 4) == 0,
             int'($urandom_range(0, 15)),
             ($urandom % 2) == 0,
             ($urandom % 3) == 0,
             ($urandom % 7) == 0,
             ($urandom % 20) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
